// File: rtl/gp_regfile_mp_if.sv
// Bus bundle for gp_regfile_mp: two lane-masked write ports, a reservation port,
// NUM_RD read ports and the collide/orphan status pulses.
interface gp_regfile_mp_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LANE_W   = 16,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned NUM_RD   = 3
);
    localparam int unsigned NLANE = DATA_W / LANE_W;
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [1:0]               wen_i;
    logic [2*IDX_W-1:0]       widx_i;
    logic [2*DATA_W-1:0]      wdata_i;
    logic [2*NLANE-1:0]       wlane_i;
    logic [1:0]               wclr_i;
    logic                     rsv_en_i;
    logic [IDX_W-1:0]         rsv_idx_i;
    logic [NUM_RD-1:0]        rd_en_i;
    logic [NUM_RD*IDX_W-1:0]  rd_idx_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic [NUM_RD-1:0]        rd_busy_o;
    logic                     wr_collide_o;
    logic                     wr_orphan_o;

    modport master (
        output wen_i, widx_i, wdata_i, wlane_i, wclr_i, rsv_en_i, rsv_idx_i, rd_en_i, rd_idx_i,
        input  rd_data_o, rd_busy_o, wr_collide_o, wr_orphan_o
    );

    modport slave (
        input  wen_i, widx_i, wdata_i, wlane_i, wclr_i, rsv_en_i, rsv_idx_i, rd_en_i, rd_idx_i,
        output rd_data_o, rd_busy_o, wr_collide_o, wr_orphan_o
    );
endinterface

// File: rtl/gp_regfile_mp.sv
// Multi-port register file with lane-masked dual write and a pending scoreboard.
// Define GP_REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module gp_regfile_mp #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       LANE_W   = 16,
    parameter int unsigned       NUM_REGS = 16,
    parameter int unsigned       NUM_RD   = 3,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    gp_regfile_mp_if.slave bus
);
    localparam int unsigned NLANE = DATA_W / LANE_W;
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                collide_q, collide_d;
    logic                orphan_q, orphan_d;

    logic [IDX_W-1:0]  widx  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [DATA_W-1:0] wmask [2];
    logic [1:0]        wclr_hit;

    // Per-port bit mask with the write enable folded in; an idle port has an all-zero mask.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            widx[p]  = bus.widx_i[p*IDX_W +: IDX_W];
            wdata[p] = bus.wdata_i[p*DATA_W +: DATA_W];
            wmask[p] = '0;
            for (int k = 0; k < NLANE; k++) begin
                wmask[p][k*LANE_W +: LANE_W] = {LANE_W{bus.wen_i[p] & bus.wlane_i[p*NLANE+k]}};
            end
        end
    end

    assign wclr_hit  = bus.wen_i & bus.wclr_i;
    assign collide_d = (widx[0] == widx[1]) && (|(wmask[0] & wmask[1]));

    // Port 1 is applied last so it wins overlapping lanes; reservation set beats clear.
    always_comb begin
        regs_d   = regs_q;
        pend_d   = pend_q;
        orphan_d = 1'b0;
        for (int p = 0; p < 2; p++) begin
            regs_d[widx[p]] = (regs_d[widx[p]] & ~wmask[p]) | (wdata[p] & wmask[p]);
            if (wclr_hit[p]) begin
                if (!pend_q[widx[p]] && !(bus.rsv_en_i && (bus.rsv_idx_i == widx[p]))) begin
                    orphan_d = 1'b1;
                end
                pend_d[widx[p]] = 1'b0;
            end
        end
        if (bus.rsv_en_i) begin
            pend_d[bus.rsv_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RST_VAL;
            end
            pend_q    <= '0;
            collide_q <= 1'b0;
            orphan_q  <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            pend_q    <= pend_d;
            collide_q <= collide_d;
            orphan_q  <= orphan_d;
        end
    end

    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [IDX_W-1:0]         ridx;
    logic [DATA_W-1:0]        rval;
    logic                     rbusy;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ridx    = '0;
        rval    = RST_VAL;
        rbusy   = 1'b0;
        for (int r = 0; r < NUM_RD; r++) begin
            ridx  = bus.rd_idx_i[r*IDX_W +: IDX_W];
            rval  = regs_q[ridx];
            rbusy = pend_q[ridx];
`ifdef GP_REGFILE_BYPASS_EN
            for (int p = 0; p < 2; p++) begin
                if (widx[p] == ridx) begin
                    rval = (rval & ~wmask[p]) | (wdata[p] & wmask[p]);
                    if (wclr_hit[p] && !(bus.rsv_en_i && (bus.rsv_idx_i == ridx))) begin
                        rbusy = 1'b0;
                    end
                end
            end
`endif
            // Reset gates the read path directly so outputs clear without a clock.
            if (!rst_n || !bus.rd_en_i[r]) begin
                rval  = RST_VAL;
                rbusy = 1'b0;
            end
            rd_data[r*DATA_W +: DATA_W] = rval;
            rd_busy[r]                  = rbusy;
        end
    end

    assign bus.rd_data_o    = rd_data;
    assign bus.rd_busy_o    = rd_busy;
    assign bus.wr_collide_o = collide_q;
    assign bus.wr_orphan_o  = orphan_q;
endmodule

// File: tb/tb_gp_regfile_mp.sv
// Directed bench for gp_regfile_mp: a lane-level register model is compared on every
// falling edge, and literal expectations pin both the model and the DUT.
module tb_gp_regfile_mp;
    localparam int unsigned DW  = 32;
    localparam int unsigned LW  = 16;
    localparam int unsigned NR  = 16;
    localparam int unsigned NRD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gp_regfile_mp_if #(.DATA_W(DW), .LANE_W(LW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

    gp_regfile_mp #(
        .DATA_W  (DW),
        .LANE_W  (LW),
        .NUM_REGS(NR),
        .NUM_RD  (NRD),
        .RST_VAL (32'h0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] m_regs [16];
    logic [15:0] m_pend;
    logic        m_coll;
    logic        m_orph;
    int          n_checks;
    int          n_fail;
    logic        checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [1:0] ln);
        return {{16{ln[1]}}, {16{ln[0]}}};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_pend = '0;
        m_coll = 1'b0;
        m_orph = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input int r);
        logic [3:0]  idx;
        logic [31:0] v;
        idx = bus.rd_idx_i[r*4 +: 4];
        if (!rst_n || !bus.rd_en_i[r]) return 32'h0;
        v = m_regs[idx];
`ifdef GP_REGFILE_BYPASS_EN
        for (int p = 0; p < 2; p++) begin
            if (bus.wen_i[p] && bus.widx_i[p*4 +: 4] == idx)
                v = (v & ~lane_mask(bus.wlane_i[p*2 +: 2]))
                  | (bus.wdata_i[p*32 +: 32] & lane_mask(bus.wlane_i[p*2 +: 2]));
        end
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input int r);
        logic [3:0] idx;
        logic       b;
        idx = bus.rd_idx_i[r*4 +: 4];
        if (!rst_n || !bus.rd_en_i[r]) return 1'b0;
        b = m_pend[idx];
`ifdef GP_REGFILE_BYPASS_EN
        for (int p = 0; p < 2; p++) begin
            if (bus.wen_i[p] && bus.wclr_i[p] && bus.widx_i[p*4 +: 4] == idx
                && !(bus.rsv_en_i && bus.rsv_idx_i == idx))
                b = 1'b0;
        end
`endif
        return b;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int r = 0; r < 3; r++) begin
                chk($sformatf("cmp rd_data[%0d]", r), bus.rd_data_o[r*32 +: 32], exp_data(r));
                chk($sformatf("cmp rd_busy[%0d]", r), 32'(bus.rd_busy_o[r]), 32'(exp_busy(r)));
            end
            chk("cmp wr_collide", 32'(bus.wr_collide_o), 32'(m_coll));
            chk("cmp wr_orphan", 32'(bus.wr_orphan_o), 32'(m_orph));
        end
    end

    task automatic wr(input int p, input logic [3:0] idx, input logic [31:0] d,
                      input logic [1:0] ln, input logic clr);
        bus.wen_i[p]           = 1'b1;
        bus.widx_i[p*4 +: 4]   = idx;
        bus.wdata_i[p*32 +: 32] = d;
        bus.wlane_i[p*2 +: 2]  = ln;
        bus.wclr_i[p]          = clr;
    endtask

    task automatic rsv(input logic [3:0] idx);
        bus.rsv_en_i  = 1'b1;
        bus.rsv_idx_i = idx;
    endtask

    task automatic rd(input int r, input logic [3:0] idx);
        bus.rd_en_i[r]       = 1'b1;
        bus.rd_idx_i[r*4 +: 4] = idx;
    endtask

    // Advance one clock; the model applies the spec's write/scoreboard rules at the edge.
    task automatic cycle();
        logic [31:0] nr [16];
        logic [15:0] np;
        logic        nc, no;
        logic [3:0]  idx;
        logic [31:0] mask;
        nr = m_regs;
        np = m_pend;
        nc = 1'b0;
        no = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (bus.wen_i[p]) begin
                idx     = bus.widx_i[p*4 +: 4];
                mask    = lane_mask(bus.wlane_i[p*2 +: 2]);
                nr[idx] = (nr[idx] & ~mask) | (bus.wdata_i[p*32 +: 32] & mask);
                if (bus.wclr_i[p]) begin
                    if (!m_pend[idx] && !(bus.rsv_en_i && bus.rsv_idx_i == idx)) no = 1'b1;
                    np[idx] = 1'b0;
                end
            end
        end
        if (bus.wen_i == 2'b11 && bus.widx_i[3:0] == bus.widx_i[7:4]
            && |(bus.wlane_i[1:0] & bus.wlane_i[3:2])) nc = 1'b1;
        if (bus.rsv_en_i) np[bus.rsv_idx_i] = 1'b1;
        @(posedge clk);
        if (rst_n) begin
            m_regs = nr;
            m_pend = np;
            m_coll = nc;
            m_orph = no;
        end
        #1;
        bus.wen_i    = '0;
        bus.wclr_i   = '0;
        bus.rsv_en_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        bus.wen_i     = '0;
        bus.widx_i    = '0;
        bus.wdata_i   = '0;
        bus.wlane_i   = '0;
        bus.wclr_i    = '0;
        bus.rsv_en_i  = 1'b0;
        bus.rsv_idx_i = '0;
        bus.rd_en_i   = '1;
        bus.rd_idx_i  = '0;
        checking      = 1'b1;
        #12 rst_n = 1'b1;

        // Write R3 + reserve, then reset mid-cycle.
        rd(0, 4'd3);
        wr(0, 4'd3, 32'hDEADBEEF, 2'b11, 1'b0);
        rsv(4'd3);
        cycle();
        #2;
        chk("R3 written", bus.rd_data_o[31:0], 32'hDEADBEEF);
        chk("R3 busy", 32'(bus.rd_busy_o[0]), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset rd_data immediate", bus.rd_data_o[31:0], 32'h0);
        chk("reset rd_busy immediate", 32'(bus.rd_busy_o), 32'd0);
        wr(0, 4'd3, 32'h12345678, 2'b11, 1'b0);
        cycle();
        #1 rst_n = 1'b1;
        #1;
        chk("R3 after reset", bus.rd_data_o[31:0], 32'h0);

        // Lane-masked writes.
        rd(0, 4'd5);
        wr(0, 4'd5, 32'h11112222, 2'b11, 1'b0);
        cycle();
        wr(0, 4'd5, 32'hAAAABBBB, 2'b10, 1'b0);
        cycle();
        #2;
        chk("lane write R5", bus.rd_data_o[31:0], 32'hAAAA2222);
        chk("model R5", m_regs[5], 32'hAAAA2222);
        wr(0, 4'd5, 32'hFFFFFFFF, 2'b00, 1'b0);
        cycle();
        #2;
        chk("zero-lane R5", bus.rd_data_o[31:0], 32'hAAAA2222);

        // Dual-write overlap and merge.
        rd(1, 4'd7);
        wr(0, 4'd7, 32'h0000FFFF, 2'b11, 1'b0);
        wr(1, 4'd7, 32'h12345678, 2'b01, 1'b0);
        cycle();
        #2;
        chk("collide R7", bus.rd_data_o[63:32], 32'h00005678);
        chk("collide pulse", 32'(bus.wr_collide_o), 32'd1);
        chk("model collide", 32'(m_coll), 32'd1);
        cycle();
        #2;
        chk("collide one cycle", 32'(bus.wr_collide_o), 32'd0);
        wr(0, 4'd7, 32'h00001111, 2'b01, 1'b0);
        wr(1, 4'd7, 32'h22220000, 2'b10, 1'b0);
        cycle();
        #2;
        chk("merge R7", bus.rd_data_o[63:32], 32'h22221111);
        chk("merge no collide", 32'(bus.wr_collide_o), 32'd0);

        // Scoreboard.
        rd(2, 4'd9);
        rsv(4'd9);
        cycle();
        #2 chk("rsv R9 busy", 32'(bus.rd_busy_o[2]), 32'd1);
        wr(0, 4'd9, 32'h00000001, 2'b11, 1'b0);
        cycle();
        #2 chk("no-clr keeps busy", 32'(bus.rd_busy_o[2]), 32'd1);
        wr(0, 4'd9, 32'h00000002, 2'b11, 1'b1);
        cycle();
        #2;
        chk("clr drops busy", 32'(bus.rd_busy_o[2]), 32'd0);
        chk("clr no orphan", 32'(bus.wr_orphan_o), 32'd0);
        rsv(4'd9);
        wr(0, 4'd9, 32'h00000003, 2'b11, 1'b1);
        cycle();
        #2;
        chk("reissue keeps busy", 32'(bus.rd_busy_o[2]), 32'd1);
        chk("reissue no orphan", 32'(bus.wr_orphan_o), 32'd0);

        // Orphan clear.
        rd(0, 4'd2);
        wr(1, 4'd2, 32'h13572468, 2'b11, 1'b1);
        cycle();
        #2;
        chk("orphan data", bus.rd_data_o[31:0], 32'h13572468);
        chk("orphan pulse", 32'(bus.wr_orphan_o), 32'd1);
        cycle();
        #2 chk("orphan one cycle", 32'(bus.wr_orphan_o), 32'd0);

        // Same-cycle read of a write.
        rd(1, 4'd4);
        wr(0, 4'd4, 32'h11111111, 2'b11, 1'b0);
        cycle();
        wr(0, 4'd4, 32'hCAFEF00D, 2'b11, 1'b0);
        #2;
`ifdef GP_REGFILE_BYPASS_EN
        chk("same-cycle R4", bus.rd_data_o[63:32], 32'hCAFEF00D);
`else
        chk("same-cycle R4", bus.rd_data_o[63:32], 32'h11111111);
`endif
        cycle();
        #2 chk("next-cycle R4", bus.rd_data_o[63:32], 32'hCAFEF00D);

        // Disabled read port hides a pending register.
        bus.rd_en_i[2] = 1'b0;
        #1;
        chk("disabled rd_data", bus.rd_data_o[95:64], 32'h0);
        chk("disabled rd_busy", 32'(bus.rd_busy_o[2]), 32'd0);

        repeat (3) cycle();
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
